// File: rtl/signal_generator_pkg.sv
// Shared types and time arithmetic for the multi-channel pulse generator.
// Time is {seconds, nanoseconds} with ns kept below one second.
package signal_generator_pkg;

  localparam logic [30:0] NS_PER_SEC    = 31'd1000000000;
  localparam logic [31:0] NS_PER_SEC_32 = 32'd1000000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_ACTIVE,
    ST_INACTIVE,
    ST_DONE,
    ST_ERROR
  } chanStateT;

  typedef struct packed {
    logic [31:0] sec;
    logic [30:0] ns;
  } timeT;

  // Adds sec/ns to a time, with at most one carry into seconds.
  function automatic timeT time_add(timeT t, logic [31:0] sec, logic [30:0] ns);
    timeT       r;
    logic [30:0] nsSum;
    nsSum = t.ns + ns;
    r.sec = t.sec + sec;
    if (nsSum >= NS_PER_SEC) begin
      r.ns  = nsSum - NS_PER_SEC;
      r.sec = r.sec + 32'd1;
    end else begin
      r.ns = nsSum;
    end
    return r;
  endfunction

  function automatic logic time_ge(timeT a, timeT b);
    return (a.sec > b.sec) || ((a.sec == b.sec) && (a.ns >= b.ns));
  endfunction

  // A 32-bit ns value can hold up to four whole seconds.
  function automatic timeT ns_to_time(logic [31:0] ns);
    timeT        r;
    logic [31:0] rem;
    r.sec = '0;
    rem   = ns;
    for (int i = 0; i < 4; i++) begin
      if (rem >= NS_PER_SEC_32) begin
        rem   = rem - NS_PER_SEC_32;
        r.sec = r.sec + 32'd1;
      end
    end
    r.ns = 31'(rem);
    return r;
  endfunction

endpackage

// File: rtl/signal_generator_channel.sv
// One pulse-train channel: shadow configuration, edge/end tracking against
// the shared time bus, and the IDLE/ARMED/ACTIVE/INACTIVE/DONE/ERROR FSM.
module signal_generator_channel
  import signal_generator_pkg::*;
#(
  parameter int CntWidth = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  timeT                currentTime,
  input  logic                timeJump,
  input  logic                timeValid,
  input  logic                enable,
  input  logic                polarity,
  input  logic [31:0]         startSec,
  input  logic [31:0]         startNs,
  input  logic [31:0]         periodSec,
  input  logic [31:0]         periodNs,
  input  logic [31:0]         pulseWidthNs,
  input  logic [CntWidth-1:0] pulseCount,
  output logic                signal,
  output logic                busy,
  output logic                error
);

  chanStateT           state, nextState;
  logic                enablePrev;
  logic                risingEnable;
  logic                configBad;
  logic                runFault;
  logic                edgeHit;
  logic                endHit;
  logic [63:0]         periodTotal;
  timeT                startTime;
  timeT                nextEdge;
  timeT                nextEnd;
  timeT                periodShadow;
  timeT                widthShadow;
  logic                shadowPol;
  logic                infinite;
  logic [CntWidth-1:0] remaining;

  assign startTime    = {startSec, startNs[30:0]};
  assign risingEnable = enable && !enablePrev;
  assign runFault     = timeJump || !timeValid;
  assign edgeHit      = time_ge(currentTime, nextEdge);
  assign endHit       = time_ge(currentTime, nextEnd);

  // Validity of the live configuration, only acted on in the latch cycle.
  always_comb begin
    periodTotal = 64'(periodSec) * 64'(NS_PER_SEC_32) + 64'(periodNs);
    configBad   = ((periodSec == '0) && (periodNs == '0))
               || (periodNs >= NS_PER_SEC_32)
               || (startNs >= NS_PER_SEC_32)
               || (pulseWidthNs == '0)
               || (64'(pulseWidthNs) >= periodTotal)
               || time_ge(currentTime, startTime);
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: begin
        if (risingEnable) nextState = configBad ? ST_ERROR : ST_ARMED;
      end
      ST_ARMED: begin
        if (runFault)     nextState = ST_ERROR;
        else if (edgeHit) nextState = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (runFault)    nextState = ST_ERROR;
        else if (endHit) nextState = ST_INACTIVE;
      end
      ST_INACTIVE: begin
        if (runFault)                          nextState = ST_ERROR;
        else if (!infinite && remaining == '0) nextState = ST_DONE;
        else if (edgeHit)                      nextState = ST_ACTIVE;
      end
      ST_DONE, ST_ERROR: nextState = state;
      default:           nextState = ST_IDLE;
    endcase
    // Disabling always wins, including over a time fault.
    if (!enable) nextState = ST_IDLE;
  end

  // enablePrev resets high so a channel left enabled through reset stays idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      enablePrev   <= 1'b1;
      nextEdge     <= '0;
      nextEnd      <= '0;
      periodShadow <= '0;
      widthShadow  <= '0;
      shadowPol    <= 1'b0;
      infinite     <= 1'b0;
      remaining    <= '0;
    end else begin
      state      <= nextState;
      enablePrev <= enable;
      if (state == ST_IDLE && risingEnable) begin
        shadowPol    <= polarity;
        nextEdge     <= startTime;
        periodShadow <= {periodSec, periodNs[30:0]};
        widthShadow  <= ns_to_time(pulseWidthNs);
        remaining    <= pulseCount;
        infinite     <= (pulseCount == '0);
      end
      if (nextState == ST_ACTIVE && (state == ST_ARMED || state == ST_INACTIVE)) begin
        nextEnd  <= time_add(nextEdge, widthShadow.sec, widthShadow.ns);
        nextEdge <= time_add(nextEdge, periodShadow.sec, periodShadow.ns);
      end
      if (state == ST_ACTIVE && nextState == ST_INACTIVE && !infinite)
        remaining <= remaining - CntWidth'(1);
    end
  end

  // Idle follows the live polarity; every other state uses the latched one.
  always_comb begin
    if (state == ST_ACTIVE)     signal = shadowPol;
    else if (state == ST_IDLE)  signal = ~polarity;
    else                        signal = ~shadowPol;
  end

  assign busy  = (state == ST_ARMED) || (state == ST_ACTIVE) || (state == ST_INACTIVE);
  assign error = (state == ST_ERROR);

endmodule

// File: rtl/signal_generator_nch.sv
// Multi-channel time-aligned pulse generator: NumChannels_Gen independent
// channels sharing the TC_Time bus, configured via flat per-channel ports.
module signal_generator_nch
  import signal_generator_pkg::*;
#(
  parameter int NumChannels_Gen = 4,
  parameter int ClockPeriod_Gen = 20,
  parameter int CntWidth_Gen    = 32
) (
  input  logic                                  SysClk_ClkIn,
  input  logic                                  SysRst_RstIn,
  input  logic [31:0]                           ClockTime_Second_DatIn,
  input  logic [31:0]                           ClockTime_Nanosecond_DatIn,
  input  logic                                  ClockTime_TimeJump_DatIn,
  input  logic                                  ClockTime_ValIn,
  input  logic [NumChannels_Gen-1:0]            Enable_DatIn,
  input  logic [NumChannels_Gen-1:0]            Polarity_DatIn,
  input  logic [NumChannels_Gen*32-1:0]         StartSec_DatIn,
  input  logic [NumChannels_Gen*32-1:0]         StartNs_DatIn,
  input  logic [NumChannels_Gen*32-1:0]         PeriodSec_DatIn,
  input  logic [NumChannels_Gen*32-1:0]         PeriodNs_DatIn,
  input  logic [NumChannels_Gen*32-1:0]         PulseWidthNs_DatIn,
  input  logic [NumChannels_Gen*CntWidth_Gen-1:0] PulseCount_DatIn,
  output logic [NumChannels_Gen-1:0]            Signal_EvtOut,
  output logic [NumChannels_Gen-1:0]            Busy_DatOut,
  output logic [NumChannels_Gen-1:0]            Error_DatOut
);

  timeT currentTime;
  logic timeOk;

  // An out-of-range ns value on the bus is treated like invalid time.
  assign currentTime = {ClockTime_Second_DatIn, ClockTime_Nanosecond_DatIn[30:0]};
  assign timeOk      = ClockTime_ValIn && (ClockTime_Nanosecond_DatIn < NS_PER_SEC_32);

  if (NumChannels_Gen >= 1 && NumChannels_Gen <= 8 && ClockPeriod_Gen > 0) begin : gen_valid
    for (genvar ch = 0; ch < NumChannels_Gen; ch++) begin : gen_ch
      signal_generator_channel #(
        .CntWidth(CntWidth_Gen)
      ) u_channel (
        .clock       (SysClk_ClkIn),
        .reset       (SysRst_RstIn),
        .currentTime (currentTime),
        .timeJump    (ClockTime_TimeJump_DatIn),
        .timeValid   (timeOk),
        .enable      (Enable_DatIn[ch]),
        .polarity    (Polarity_DatIn[ch]),
        .startSec    (StartSec_DatIn[ch*32 +: 32]),
        .startNs     (StartNs_DatIn[ch*32 +: 32]),
        .periodSec   (PeriodSec_DatIn[ch*32 +: 32]),
        .periodNs    (PeriodNs_DatIn[ch*32 +: 32]),
        .pulseWidthNs(PulseWidthNs_DatIn[ch*32 +: 32]),
        .pulseCount  (PulseCount_DatIn[ch*CntWidth_Gen +: CntWidth_Gen]),
        .signal      (Signal_EvtOut[ch]),
        .busy        (Busy_DatOut[ch]),
        .error       (Error_DatOut[ch])
      );
    end
  end else begin : gen_invalid
    assign Signal_EvtOut = ~Polarity_DatIn;
    assign Busy_DatOut   = '0;
    assign Error_DatOut  = '0;
  end

endmodule

// File: tb/tb_signal_generator_nch.sv
// Directed testbench for signal_generator_nch: the bench drives the time bus
// directly so second-scale schedules need only a handful of clocks.
module tb_signal_generator_nch;

  localparam int NumCh = 4;
  localparam int CntW  = 32;

  logic                    clk;
  logic                    rst;
  logic [31:0]             timeSec;
  logic [31:0]             timeNs;
  logic                    timeJump;
  logic                    timeValid;
  logic [NumCh-1:0]        enable;
  logic [NumCh-1:0]        polarity;
  logic [NumCh*32-1:0]     startSec;
  logic [NumCh*32-1:0]     startNs;
  logic [NumCh*32-1:0]     periodSec;
  logic [NumCh*32-1:0]     periodNs;
  logic [NumCh*32-1:0]     widthNs;
  logic [NumCh*CntW-1:0]   pulseCount;
  logic [NumCh-1:0]        signalOut;
  logic [NumCh-1:0]        busy;
  logic [NumCh-1:0]        errorOut;

  int compared   = 0;
  int mismatched = 0;

  signal_generator_nch #(
    .NumChannels_Gen(NumCh),
    .ClockPeriod_Gen(20),
    .CntWidth_Gen   (CntW)
  ) dut (
    .SysClk_ClkIn              (clk),
    .SysRst_RstIn              (rst),
    .ClockTime_Second_DatIn    (timeSec),
    .ClockTime_Nanosecond_DatIn(timeNs),
    .ClockTime_TimeJump_DatIn  (timeJump),
    .ClockTime_ValIn           (timeValid),
    .Enable_DatIn              (enable),
    .Polarity_DatIn            (polarity),
    .StartSec_DatIn            (startSec),
    .StartNs_DatIn             (startNs),
    .PeriodSec_DatIn           (periodSec),
    .PeriodNs_DatIn            (periodNs),
    .PulseWidthNs_DatIn        (widthNs),
    .PulseCount_DatIn          (pulseCount),
    .Signal_EvtOut             (signalOut),
    .Busy_DatOut               (busy),
    .Error_DatOut              (errorOut)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // One clock, then settle 1 ns past the edge before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] sec, input logic [31:0] ns);
    timeSec = sec;
    timeNs  = ns;
    step();
  endtask

  task automatic setChannel(input int ch, input logic [31:0] sSec, input logic [31:0] sNs,
                            input logic [31:0] pSec, input logic [31:0] pNs,
                            input logic [31:0] w, input logic [31:0] cnt, input logic pol);
    startSec[ch*32 +: 32]     = sSec;
    startNs[ch*32 +: 32]      = sNs;
    periodSec[ch*32 +: 32]    = pSec;
    periodNs[ch*32 +: 32]     = pNs;
    widthNs[ch*32 +: 32]      = w;
    pulseCount[ch*CntW +: CntW] = cnt;
    polarity[ch]              = pol;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    polarity  = 4'b0101;
    enable    = '0;
    timeJump  = 1'b0;
    timeValid = 1'b1;
    applyStimulus(32'd1, 32'd0);
    applyStimulus(32'd1, 32'd20);
    compared++;
    if ({signalOut, busy, errorOut} !== 12'b1010_0000_0000) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got sig/busy/err=%b expected %b",
               {signalOut, busy, errorOut}, 12'b1010_0000_0000);
    end
    rst = 1'b0;
    applyStimulus(32'd1, 32'd40);
    compared++;
    if ({signalOut, busy, errorOut} !== 12'b1010_0000_0000) begin
      mismatched++;
      $display("[TB] FAIL after_reset_idle: got %b expected %b",
               {signalOut, busy, errorOut}, 12'b1010_0000_0000);
    end
  endtask

  // Ch0: three 100 ms active-high pulses at 10 s, 11 s and 12 s, then DONE.
  task automatic test_pulse_train();
    logic [31:0] secTab [13] = '{32'd9, 32'd9, 32'd10, 32'd10, 32'd10, 32'd10, 32'd11,
                                 32'd11, 32'd11, 32'd12, 32'd12, 32'd12, 32'd13};
    logic [31:0] nsTab  [13] = '{32'd999999000, 32'd999999980, 32'd0, 32'd99999980,
                                 32'd100000000, 32'd999999980, 32'd0, 32'd99999980,
                                 32'd100000000, 32'd0, 32'd100000000, 32'd100000020, 32'd0};
    logic [2:0]  expTab [13] = '{3'b010, 3'b010, 3'b110, 3'b110, 3'b010, 3'b010, 3'b110,
                                 3'b110, 3'b010, 3'b110, 3'b010, 3'b000, 3'b000};
    setChannel(0, 32'd10, 32'd0, 32'd1, 32'd0, 32'd100000000, 32'd3, 1'b1);
    enable[0] = 1'b1;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(secTab[i], nsTab[i]);
      compared++;
      if ({signalOut[0], busy[0], errorOut[0]} !== expTab[i]) begin
        mismatched++;
        $display("[TB] FAIL pulse_train[%0d]: got sig/busy/err=%b expected %b",
                 i, {signalOut[0], busy[0], errorOut[0]}, expTab[i]);
      end
    end
    enable[0] = 1'b0;
    applyStimulus(32'd13, 32'd20);
    compared++;
    if ({signalOut[0], busy[0], errorOut[0]} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL pulse_train_disable: got %b expected %b",
               {signalOut[0], busy[0], errorOut[0]}, 3'b000);
    end
  endtask

  // Ch1: active-low, 500 ms period, infinite; edges straddle second boundaries.
  task automatic test_ns_carry();
    logic [31:0] secTab [13] = '{32'd20, 32'd20, 32'd20, 32'd20, 32'd20, 32'd21, 32'd21,
                                 32'd21, 32'd21, 32'd21, 32'd21, 32'd22, 32'd22};
    logic [31:0] nsTab  [13] = '{32'd0, 32'd699999980, 32'd700000000, 32'd949999980,
                                 32'd950000000, 32'd199999980, 32'd200000000, 32'd450000000,
                                 32'd699999980, 32'd700000000, 32'd950000000, 32'd199999980,
                                 32'd200000000};
    logic [2:0]  expTab [13] = '{3'b110, 3'b110, 3'b010, 3'b010, 3'b110, 3'b110, 3'b010,
                                 3'b110, 3'b110, 3'b010, 3'b110, 3'b110, 3'b010};
    setChannel(1, 32'd20, 32'd700000000, 32'd0, 32'd500000000, 32'd250000000, 32'd0, 1'b0);
    enable[1] = 1'b1;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(secTab[i], nsTab[i]);
      compared++;
      if ({signalOut[1], busy[1], errorOut[1]} !== expTab[i]) begin
        mismatched++;
        $display("[TB] FAIL ns_carry[%0d]: got sig/busy/err=%b expected %b",
                 i, {signalOut[1], busy[1], errorOut[1]}, expTab[i]);
      end
    end
  endtask

  // Ch0 mid-pulse and ch1 running when the time bus reports a step.
  task automatic test_time_jump();
    logic [31:0] secTab  [7] = '{32'd22, 32'd22, 32'd22, 32'd22, 32'd23, 32'd23, 32'd23};
    logic [31:0] nsTab   [7] = '{32'd200000020, 32'd450000000, 32'd700000000, 32'd950000000,
                                 32'd0, 32'd50000000, 32'd50000020};
    logic        jumpTab [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [5:0]  expTab  [7] = '{6'b010_010, 6'b010_110, 6'b010_010, 6'b010_110,
                                 6'b110_110, 6'b001_101, 6'b001_101};
    setChannel(0, 32'd23, 32'd0, 32'd1, 32'd0, 32'd100000000, 32'd0, 1'b1);
    enable[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      timeJump = jumpTab[i];
      applyStimulus(secTab[i], nsTab[i]);
      compared++;
      if ({signalOut[0], busy[0], errorOut[0], signalOut[1], busy[1], errorOut[1]} !== expTab[i]) begin
        mismatched++;
        $display("[TB] FAIL time_jump[%0d]: got ch0/ch1 sig,busy,err=%b expected %b", i,
                 {signalOut[0], busy[0], errorOut[0], signalOut[1], busy[1], errorOut[1]},
                 expTab[i]);
      end
    end
    enable[1:0] = 2'b00;
    applyStimulus(32'd23, 32'd50000040);
    compared++;
    if ({signalOut[0], busy[0], errorOut[0], signalOut[1], busy[1], errorOut[1]} !== 6'b000_100) begin
      mismatched++;
      $display("[TB] FAIL time_jump_clear: got %b expected %b",
               {signalOut[0], busy[0], errorOut[0], signalOut[1], busy[1], errorOut[1]},
               6'b000_100);
    end
  endtask

  // Ch2: each row is one enable attempt with a different period/width pair.
  task automatic test_config_error();
    logic [31:0] pSecTab [6] = '{32'd1, 32'd1, 32'd0, 32'd0, 32'd1, 32'd2};
    logic [31:0] pNsTab  [6] = '{32'd0, 32'd0, 32'd1000000000, 32'd0, 32'd0, 32'd0};
    logic [31:0] wTab    [6] = '{32'd1000000000, 32'd999999999, 32'd10, 32'd10, 32'd0,
                                 32'd1500000000};
    logic [2:0]  expTab  [6] = '{3'b001, 3'b010, 3'b001, 3'b001, 3'b001, 3'b010};
    for (int i = 0; i < 6; i++) begin
      setChannel(2, 32'd30, 32'd0, pSecTab[i], pNsTab[i], wTab[i], 32'd0, 1'b1);
      enable[2] = 1'b1;
      applyStimulus(32'd25, 32'd0);
      compared++;
      if ({signalOut[2], busy[2], errorOut[2]} !== expTab[i]) begin
        mismatched++;
        $display("[TB] FAIL config_check[%0d]: got sig/busy/err=%b expected %b",
                 i, {signalOut[2], busy[2], errorOut[2]}, expTab[i]);
      end
      applyStimulus(32'd25, 32'd20);
      compared++;
      if ({signalOut[2], busy[2], errorOut[2]} !== expTab[i]) begin
        mismatched++;
        $display("[TB] FAIL config_hold[%0d]: got %b expected %b",
                 i, {signalOut[2], busy[2], errorOut[2]}, expTab[i]);
      end
      enable[2] = 1'b0;
      applyStimulus(32'd25, 32'd40);
      compared++;
      if ({signalOut[2], busy[2], errorOut[2]} !== 3'b000) begin
        mismatched++;
        $display("[TB] FAIL config_disable[%0d]: got %b expected %b",
                 i, {signalOut[2], busy[2], errorOut[2]}, 3'b000);
      end
    end
  endtask

  // Ch3: past/equal start times, disable mid-pulse, and loss of time valid.
  task automatic test_start_and_disable();
    logic [31:0] sSecTab [10] = '{32'd5, 32'd5, 32'd6, 32'd6, 32'd6, 32'd6, 32'd6,
                                  32'd7, 32'd7, 32'd7};
    logic [31:0] sNsTab  [10] = '{32'd0, 32'd0, 32'd40, 32'd40, 32'd100, 32'd100, 32'd100,
                                  32'd0, 32'd0, 32'd0};
    logic [31:0] nsTab   [10] = '{32'd0, 32'd20, 32'd40, 32'd60, 32'd80, 32'd100, 32'd120,
                                  32'd140, 32'd160, 32'd180};
    logic        enTab   [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        valTab  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0]  expTab  [10] = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b010, 3'b110, 3'b000,
                                  3'b010, 3'b001, 3'b000};
    for (int i = 0; i < 10; i++) begin
      setChannel(3, sSecTab[i], sNsTab[i], 32'd1, 32'd0, 32'd100000000, 32'd0, 1'b1);
      enable[3] = enTab[i];
      timeValid = valTab[i];
      applyStimulus(32'd6, nsTab[i]);
      compared++;
      if ({signalOut[3], busy[3], errorOut[3]} !== expTab[i]) begin
        mismatched++;
        $display("[TB] FAIL start_disable[%0d]: got sig/busy/err=%b expected %b",
                 i, {signalOut[3], busy[3], errorOut[3]}, expTab[i]);
      end
    end
    timeValid = 1'b1;
  endtask

  // All four channels mid-pulse when reset is pulsed for one clock.
  task automatic test_reset_mid_pulse();
    for (int ch = 0; ch < NumCh; ch++)
      setChannel(ch, 32'd50, 32'd0, 32'd1, 32'd0, 32'd200000000, 32'd0, ch[0]);
    enable = 4'b1111;
    applyStimulus(32'd49, 32'd900000000);
    compared++;
    if ({signalOut, busy, errorOut} !== 12'b0101_1111_0000) begin
      mismatched++;
      $display("[TB] FAIL all_armed: got %b expected %b", {signalOut, busy, errorOut},
               12'b0101_1111_0000);
    end
    applyStimulus(32'd50, 32'd0);
    compared++;
    if ({signalOut, busy, errorOut} !== 12'b1010_1111_0000) begin
      mismatched++;
      $display("[TB] FAIL all_active: got %b expected %b", {signalOut, busy, errorOut},
               12'b1010_1111_0000);
    end
    rst = 1'b1;
    applyStimulus(32'd50, 32'd50000000);
    compared++;
    if ({signalOut, busy, errorOut} !== 12'b0101_0000_0000) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_pulse: got %b expected %b", {signalOut, busy, errorOut},
               12'b0101_0000_0000);
    end
    rst = 1'b0;
    applyStimulus(32'd50, 32'd100000000);
    compared++;
    if ({signalOut, busy, errorOut} !== 12'b0101_0000_0000) begin
      mismatched++;
      $display("[TB] FAIL no_rearm_after_reset: got %b expected %b",
               {signalOut, busy, errorOut}, 12'b0101_0000_0000);
    end
    enable = 4'b0000;
    applyStimulus(32'd50, 32'd150000000);
    for (int ch = 0; ch < NumCh; ch++)
      setChannel(ch, 32'd51, 32'd0, 32'd1, 32'd0, 32'd200000000, 32'd0, ch[0]);
    enable = 4'b1111;
    applyStimulus(32'd50, 32'd200000000);
    compared++;
    if ({signalOut, busy, errorOut} !== 12'b0101_1111_0000) begin
      mismatched++;
      $display("[TB] FAIL rearm_on_new_edge: got %b expected %b",
               {signalOut, busy, errorOut}, 12'b0101_1111_0000);
    end
    applyStimulus(32'd51, 32'd0);
    compared++;
    if ({signalOut, busy, errorOut} !== 12'b1010_1111_0000) begin
      mismatched++;
      $display("[TB] FAIL rearm_active: got %b expected %b",
               {signalOut, busy, errorOut}, 12'b1010_1111_0000);
    end
  endtask

  initial begin
    rst        = 1'b1;
    timeSec    = '0;
    timeNs     = '0;
    timeJump   = 1'b0;
    timeValid  = 1'b1;
    enable     = '0;
    polarity   = '0;
    startSec   = '0;
    startNs    = '0;
    periodSec  = '0;
    periodNs   = '0;
    widthNs    = '0;
    pulseCount = '0;
    test_reset();
    test_pulse_train();
    test_ns_carry();
    test_time_jump();
    test_config_error();
    test_start_and_disable();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
